fpu_dispatcher: RTL and testbench

Command queue and sequencer that sits directly upstream of the `FPU` core. It accepts (operation, operand A, operand B) requests on a valid/ready port and buffers them in a small FIFO. It issues each request to the FPU by holding operands and raising a start pulse on the core's start/clear input, then waits for the core's `Done` rising edge. It returns the result on a valid/ready output port, with a timeout guard against a hung core.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_cmd_fifo.sv | 60 ++++++
 rtl/fpu_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_fpu_dispatcher.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// fpu_pkg: operation/state encodings and IEEE-754 special-value constants
// shared by the FPU core and its dispatcher.                    Rev 1.0
// ============================================================================
package fpu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Values are right-aligned in 64 bits; callers slice to their precision.
   function automatic logic [63:0] nan_bits(input int prec);
      return (prec == 32) ? 64'h0000_0000_7FFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] inf_bits(input int prec);
      return (prec == 32) ? 64'h0000_0000_7F80_0000 : 64'h7FF0_0000_0000_0000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// fpu_cmd_fifo: command FIFO with registered storage and occupancy count.
//                                                                 Rev 1.0
// ============================================================================
module fpu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 130
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == c_full);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full FIFO refuses pushes even when a pop frees a slot this cycle.
   assign w_push = push_i && !full_o;
   assign w_pop  = pop_i && !empty_o;

   always_ff @(posedge Clk) begin
      if (w_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
         if (w_push && !w_pop)      count_q <= count_q + c_cnt_one;
         else if (w_pop && !w_push) count_q <= count_q - c_cnt_one;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpu_dispatcher.sv
`default_nettype none
// ============================================================================
// fpu_dispatcher: buffers FPU requests, issues them with a start pulse and
// returns results (or a timeout NaN) on a valid/ready port.      Rev 1.0
// ============================================================================
module fpu_dispatcher
   import fpu_pkg::*;
#(
   parameter int PRECISION    = 64,
   parameter int DEPTH        = 4,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 4095
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_op,
   input  logic [PRECISION-1:0]     in_a,
   input  logic [PRECISION-1:0]     in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PRECISION-1:0]     out_result,
   output logic [1:0]               out_op,
   output logic                     out_timeout,
   output logic [PRECISION-1:0]     fpu_a,
   output logic [PRECISION-1:0]     fpu_b,
   output logic [1:0]               fpu_op,
   output logic                     fpu_start,
   input  logic [PRECISION-1:0]     fpu_result,
   input  logic                     fpu_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int FW = 2 + 2 * PRECISION;
   localparam int CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0]        c_start_last = CW'(START_CYCLES - 1);
   localparam logic [CW-1:0]        c_to_last    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]        c_cnt_one    = CW'(1);
   localparam logic [63:0]          c_nan64      = nan_bits(PRECISION);
   localparam logic [PRECISION-1:0] c_nan        = c_nan64[PRECISION-1:0];

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic                   done_q;
   logic [PRECISION-1:0]   fpu_a_q;
   logic [PRECISION-1:0]   fpu_b_q;
   op_t                    fpu_op_q;
   logic                   fpu_start_q;
   logic                   out_valid_q;
   logic [PRECISION-1:0]   out_result_q;
   op_t                    out_op_q;
   logic                   out_timeout_q;
   logic                   busy_q;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_done_edge;
   logic [FW-1:0]          w_head;
   logic [1:0]             w_head_op;
   logic [PRECISION-1:0]   w_head_a;
   logic [PRECISION-1:0]   w_head_b;

   assign in_ready    = !w_full;
   assign w_push      = in_valid && in_ready;
   assign w_pop       = (state_q == IDLE) && !w_empty;
   assign w_done_edge = fpu_done && !done_q;
   assign {w_head_op, w_head_a, w_head_b} = w_head;

   fpu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  ({in_op, in_a, in_b}),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (count)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         fpu_a_q       <= '0;
         fpu_b_q       <= '0;
         fpu_op_q      <= OP_ADD;
         fpu_start_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_op_q      <= OP_ADD;
         out_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         done_q <= fpu_done;
         case (state_q)
            IDLE: begin
               if (!w_empty) begin
                  fpu_a_q     <= w_head_a;
                  fpu_b_q     <= w_head_b;
                  fpu_op_q    <= op_t'(w_head_op);
                  fpu_start_q <= 1'b1;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= START;
               end
            end
            // Done activity is deliberately not examined while start is held.
            START: begin
               if (cnt_q == c_start_last) begin
                  fpu_start_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= WAIT;
               end else begin
                  cnt_q <= cnt_q + c_cnt_one;
               end
            end
            WAIT: begin
               if (w_done_edge) begin
                  out_result_q  <= fpu_result;
                  out_op_q      <= fpu_op_q;
                  out_timeout_q <= 1'b0;
                  out_valid_q   <= 1'b1;
                  state_q       <= OUT;
               end else if (cnt_q == c_to_last) begin
                  out_result_q  <= c_nan;
                  out_op_q      <= fpu_op_q;
                  out_timeout_q <= 1'b1;
                  out_valid_q   <= 1'b1;
                  state_q       <= OUT;
               end else begin
                  cnt_q <= cnt_q + c_cnt_one;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fpu_a       = fpu_a_q;
   assign fpu_b       = fpu_b_q;
   assign fpu_op      = fpu_op_q;
   assign fpu_start   = fpu_start_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_op      = out_op_q;
   assign out_timeout = out_timeout_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatcher.sv
`default_nettype none
// ============================================================================
// tb_fpu_dispatcher: scoreboard bench with a behavioural FPU core model.
//                                                                 Rev 1.0
// ============================================================================
module tb_fpu_dispatcher;

   localparam logic [63:0] D0_25 = 64'h3FD0_0000_0000_0000;
   localparam logic [63:0] D0_5  = 64'h3FE0_0000_0000_0000;
   localparam logic [63:0] D0_75 = 64'h3FE8_0000_0000_0000;
   localparam logic [63:0] D1    = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] D1_5  = 64'h3FF8_0000_0000_0000;
   localparam logic [63:0] D2    = 64'h4000_0000_0000_0000;
   localparam logic [63:0] D2_25 = 64'h4002_0000_0000_0000;
   localparam logic [63:0] D3    = 64'h4008_0000_0000_0000;
   localparam logic [63:0] D5    = 64'h4014_0000_0000_0000;
   localparam logic [63:0] D6    = 64'h4018_0000_0000_0000;
   localparam logic [63:0] D9    = 64'h4022_0000_0000_0000;
   localparam logic [63:0] DNAN  = 64'h7FFF_FFFF_FFFF_FFFF;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        in_valid, in_ready, out_valid, out_ready, out_timeout;
   logic [1:0]  in_op, out_op, fpu_op;
   logic [63:0] in_a, in_b, out_result, fpu_a, fpu_b, fpu_result;
   logic        fpu_start, fpu_done, busy;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] res;
      logic [1:0]  op;
      logic        to;
   } exp_t;
   exp_t sb[$];

   // Core model: mode 0 answers 10 cycles after start falls, 1 never answers,
   // 2 hands fpu_done/fpu_result to the running test.
   int          mode = 0;
   logic        man_done = 1'b0;
   logic [63:0] man_result = '0;
   logic        model_done = 1'b0;
   logic [63:0] model_result = '0;
   logic        prev_start = 1'b0;
   int          dly = 0;
   int          hold = 0;

   assign fpu_done   = (mode == 2) ? man_done : (mode == 1) ? 1'b0 : model_done;
   assign fpu_result = (mode == 2) ? man_result : model_result;

   always #5 Clk = ~Clk;

   fpu_dispatcher #(
      .PRECISION    (64),
      .DEPTH        (4),
      .START_CYCLES (2),
      .TIMEOUT      (50)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_op      (out_op),
      .out_timeout (out_timeout),
      .fpu_a       (fpu_a),
      .fpu_b       (fpu_b),
      .fpu_op      (fpu_op),
      .fpu_start   (fpu_start),
      .fpu_result  (fpu_result),
      .fpu_done    (fpu_done),
      .busy        (busy),
      .count       (count)
   );

   function automatic logic [63:0] calc(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      real ra, rb, r;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      case (op)
         2'b00:   r = ra + rb;
         2'b01:   r = ra - rb;
         2'b10:   r = ra * rb;
         default: r = ra / rb;
      endcase
      return $realtobits(r);
   endfunction

   always @(negedge Clk) begin
      if (!Reset) begin
         prev_start = 1'b0;
         dly = 0;
         hold = 0;
         model_done = 1'b0;
      end else begin
         if (prev_start && !fpu_start) begin
            dly = 10;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               model_result = calc(fpu_op, fpu_a, fpu_b);
               model_done = 1'b1;
               hold = 2;
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) model_done = 1'b0;
         end
         prev_start = fpu_start;
      end
   end

   // Output monitor: every handshake pops and checks one scoreboard entry.
   always @(negedge Clk) begin
      exp_t e;
      if (Reset && out_valid && out_ready) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got result=%h op=%0d timeout=%0b, required no output",
                     out_result, out_op, out_timeout);
         end else begin
            e = sb.pop_front();
            if (out_result !== e.res || out_op !== e.op || out_timeout !== e.to) begin
               n_fail++;
               $display("FAIL result: got result=%h op=%0d timeout=%0b, required result=%h op=%0d timeout=%0b",
                        out_result, out_op, out_timeout, e.res, e.op, e.to);
            end
         end
      end
   end

   task automatic push(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic eto, input bit track);
      int t;
      exp_t e;
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 300) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 300) begin
         n_tests++; n_fail++;
         $display("FAIL push_wait: got in_ready=0 for %0d cycles, required 1", t);
      end
      if (track) begin
         e.res = er; e.op = op; e.to = eto;
         sb.push_back(e);
      end
      @(posedge Clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy) && t < 1000) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 1000) begin
         n_tests++; n_fail++;
         $display("FAIL drain: got %0d results pending busy=%0b, required 0 and 0", sb.size(), busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clk);
      n_tests++;
      if ({out_valid, out_timeout, fpu_start, busy} !== 4'b0000 || in_ready !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ov=%0b to=%0b st=%0b busy=%0b rdy=%0b cnt=%0d, required 0 0 0 0 1 0",
                  out_valid, out_timeout, fpu_start, busy, in_ready, count);
      end
      n_tests++;
      if (out_result !== 64'd0 || out_op !== 2'd0 || fpu_a !== 64'd0 || fpu_b !== 64'd0 || fpu_op !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_data: got res=%h oop=%0d a=%h b=%h op=%0d, required all zero",
                  out_result, out_op, fpu_a, fpu_b, fpu_op);
      end
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_single_mul();
      out_ready = 1'b1;
      push(2'b10, D1_5, D1_5, D2_25, 1'b0, 1'b1);
      @(negedge Clk);
      n_tests++;
      if (count !== 3'd1 || fpu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_edge: got count=%0d start=%0b, required 1 0", count, fpu_start);
      end
      @(negedge Clk);
      n_tests++;
      if (fpu_start !== 1'b1 || count !== 3'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pop_edge: got start=%0b count=%0d busy=%0b, required 1 0 1", fpu_start, count, busy);
      end
      n_tests++;
      if (fpu_a !== D1_5 || fpu_b !== D1_5 || fpu_op !== 2'b10) begin
         n_fail++;
         $display("FAIL issue_reg: got a=%h b=%h op=%0d, required %h %h 2", fpu_a, fpu_b, fpu_op, D1_5, D1_5);
      end
      @(negedge Clk);
      n_tests++;
      if (fpu_start !== 1'b1) begin
         n_fail++;
         $display("FAIL start_cycle2: got %0b, required 1", fpu_start);
      end
      @(negedge Clk);
      n_tests++;
      if (fpu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL start_cycle3: got %0b, required 0", fpu_start);
      end
      wait_drain();
   endtask

   task automatic test_burst();
      out_ready = 1'b0;
      push(2'b00, D1,   D1,   D2,    1'b0, 1'b1);
      push(2'b01, D5,   D2,   D3,    1'b0, 1'b1);
      push(2'b10, D2,   D3,   D6,    1'b0, 1'b1);
      push(2'b11, D9,   D3,   D3,    1'b0, 1'b1);
      push(2'b00, D0_5, D0_25, D0_75, 1'b0, 1'b1);
      n_tests++;
      if (in_ready !== 1'b0 || count !== 3'd4) begin
         n_fail++;
         $display("FAIL burst_full: got in_ready=%0b count=%0d, required 0 4", in_ready, count);
      end
      in_op = 2'b11; in_a = D1; in_b = D1; in_valid = 1'b1;
      repeat (3) @(posedge Clk);
      #1 in_valid = 1'b0;
      n_tests++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_refuse: got count=%0d, required 4", count);
      end
      out_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_backpressure();
      int t;
      logic [63:0] r0;
      logic [1:0]  o0;
      bit bad;
      out_ready = 1'b0;
      push(2'b11, D6, D2, D3, 1'b0, 1'b1);
      push(2'b00, D2, D3, 64'h4014_0000_0000_0000, 1'b0, 1'b1);
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge Clk);
         t++;
      end
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_valid: got out_valid=%0b, required 1", out_valid);
      end
      r0 = out_result; o0 = out_op; bad = 0;
      repeat (20) begin
         @(negedge Clk);
         if (out_valid !== 1'b1 || out_result !== r0 || out_op !== o0 || fpu_start !== 1'b0) bad = 1;
      end
      n_tests++;
      if (bad || count !== 3'd1) begin
         n_fail++;
         $display("FAIL bp_hold: got unstable=%0b count=%0d, required 0 1", bad, count);
      end
      @(posedge Clk);
      #1 out_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      n_tests++;
      if (out_valid !== 1'b0 || fpu_start !== 1'b0 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL bp_bubble: got ov=%0b start=%0b count=%0d, required 0 0 1", out_valid, fpu_start, count);
      end
      @(negedge Clk);
      n_tests++;
      if (fpu_start !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL bp_pop: got start=%0b count=%0d, required 1 0", fpu_start, count);
      end
      wait_drain();
   endtask

   task automatic test_timeout();
      int t, n;
      mode = 1;
      out_ready = 1'b1;
      push(2'b00, D1, D1, DNAN, 1'b1, 1'b1);
      t = 0;
      while (fpu_start !== 1'b1 && t < 20) begin @(negedge Clk); t++; end
      while (fpu_start !== 1'b0 && t < 40) begin @(negedge Clk); t++; end
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge Clk);
         n++;
      end
      n_tests++;
      if (n !== 50) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d, required 50", n);
      end
      wait_drain();
      repeat (20) @(negedge Clk);
      mode = 0;
   endtask

   task automatic test_stuck_done();
      bit bad;
      mode = 2; man_done = 1'b1; man_result = 64'hDEAD_BEEF_0000_0001;
      out_ready = 1'b1;
      repeat (2) @(negedge Clk);
      push(2'b10, D2, D3, D6, 1'b0, 1'b1);
      @(negedge Clk);
      man_done = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (fpu_start !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_in_start: got start=%0b, required 1", fpu_start);
      end
      man_done = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge Clk);
         if (out_valid !== 1'b0) bad = 1;
      end
      n_tests++;
      if (bad || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stuck_ignored: got early_valid=%0b busy=%0b, required 0 1", bad, busy);
      end
      man_result = D6;
      man_done = 1'b0;
      @(negedge Clk);
      man_done = 1'b1;
      wait_drain();
      man_done = 1'b0;
      repeat (20) @(negedge Clk);
      mode = 0;
   endtask

   task automatic test_reset_mid();
      int t;
      bit bad;
      mode = 1;
      out_ready = 1'b1;
      push(2'b00, D1, D1, D2, 1'b0, 1'b0);
      push(2'b01, D5, D2, D3, 1'b0, 1'b0);
      push(2'b10, D2, D3, D6, 1'b0, 1'b0);
      push(2'b11, D9, D3, D3, 1'b0, 1'b0);
      t = 0;
      while (!(busy && !fpu_start) && t < 40) begin @(negedge Clk); t++; end
      repeat (3) @(negedge Clk);
      n_tests++;
      if (count !== 3'd3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got count=%0d busy=%0b, required 3 1", count, busy);
      end
      #2 Reset = 1'b0;
      #1;
      n_tests++;
      if (count !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || fpu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_ctrl: got count=%0d busy=%0b rdy=%0b ov=%0b st=%0b, required 0 0 1 0 0",
                  count, busy, in_ready, out_valid, fpu_start);
      end
      n_tests++;
      if (fpu_a !== 64'd0 || fpu_b !== 64'd0 || fpu_op !== 2'd0 || out_result !== 64'd0 || out_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_data: got a=%h b=%h op=%0d res=%h to=%0b, required all zero",
                  fpu_a, fpu_b, fpu_op, out_result, out_timeout);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      mode = 0;
      bad = 0;
      repeat (80) begin
         @(negedge Clk);
         if (out_valid !== 1'b0 || busy !== 1'b0 || fpu_start !== 1'b0) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL post_reset_quiet: got activity=%0b, required 0", bad);
      end
      push(2'b00, D0_5, D0_25, D0_75, 1'b0, 1'b1);
      wait_drain();
   endtask

   initial begin
      in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
      test_reset();
      test_single_mul();
      test_burst();
      test_backpressure();
      test_timeout();
      test_stuck_done();
      test_reset_mid();
      n_tests++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
